usbf_ep_tx_fifo: RTL and testbench
==================================

USBF_EP_TX_FIFO -- requirements
Module: usbf_ep_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of one endpoint data word.
REQ-002 SHALL have parameter DEPTH, default 64, meaning FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter LEN_W, default 11, meaning packet length width in words.
REQ-004 SHALL have port phy_clk_i, input, 1, the single clock; all logic is in the PHY domain.
REQ-005 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port wt_req_i, input, 1, one-cycle write strobe, already synchronized to phy_clk_i.
REQ-007 SHALL have port wt_data_i, input, DATA_W, write data, valid while wt_req_i is high.
REQ-008 SHALL have port flush_i, input, 1, one-cycle flush strobe, already synchronized.
REQ-009 SHALL have port tx_start_i, input, 1, one-cycle packet start strobe, already synchronized.
REQ-010 SHALL have port tx_len_i, input, LEN_W, packet length in words, sampled on tx_start_i.
REQ-011 SHALL have port tx_ready_i, input, 1, packet engine accepts the current word.
REQ-012 SHALL have port tx_abort_i, input, 1, packet engine abandons the packet.
REQ-013 SHALL have port tx_pkt_req_o, output, 1, packet pending; high during SEND.
REQ-014 SHALL have port tx_pkt_len_o, output, LEN_W, latched packet length.
REQ-015 SHALL have port tx_valid_o, output, 1, tx_data_o holds a word of the packet.
REQ-016 SHALL have port tx_data_o, output, DATA_W, head-of-FIFO word (first-word fall-through).
REQ-017 SHALL have port tx_last_o, output, 1, current word is the last word of the packet.
REQ-018 SHALL have port tx_complete_o, output, 1, one-cycle pulse when the packet is done.
REQ-019 SHALL have port tx_busy_o, output, 1, level; state is not IDLE.
REQ-020 SHALL have port tx_err_o, output, 1, sticky; set on abort or overflow.
REQ-021 SHALL have port count_o, output, log2(DEPTH)+1, number of stored words.

Function
REQ-022 SHALL use read and write pointers one bit wider than log2(DEPTH); full when the MSBs differ and the rest match, empty when the pointers are equal; pointers wrap modulo 2*DEPTH.
REQ-023 SHALL store wt_data_i and advance the write pointer on wt_req_i when not full; a write while full SHALL be dropped and SHALL set tx_err_o.
REQ-024 SHALL make a stored word visible on count_o and tx_data_o one cycle after its wt_req_i.
REQ-025 SHALL have state machine IDLE, SEND and DONE.
- IDLE: tx_start_i goes to SEND; load remaining and tx_pkt_len_o from tx_len_i.
- SEND: tx_start_i is ignored.
- DONE: lasts exactly one cycle, then goes to IDLE.
REQ-026 SHALL, in SEND, drive tx_valid_o = (count != 0) and (remaining != 0).
- A pop occurs when tx_valid_o and tx_ready_i are both high.
- Each pop decrements remaining and advances the read pointer.
- While the FIFO is empty, tx_valid_o SHALL be low and SEND SHALL wait (underrun stall).
REQ-027 SHALL drive tx_last_o = tx_valid_o and (remaining == 1).
REQ-028 SHALL go from SEND to DONE in the cycle after the pop that brings remaining to 0.
REQ-029 SHALL, for tx_len_i = 0 (zero-length packet), keep tx_valid_o low, hold SEND one cycle, then go to DONE.
REQ-030 SHALL assert tx_complete_o only in DONE.
REQ-031 SHALL, on tx_abort_i in SEND, go to IDLE in the next cycle.
- tx_complete_o SHALL NOT pulse.
- tx_err_o SHALL be set.
- Popped words are lost; unpopped words are kept.
REQ-032 SHALL, on flush_i, in the next cycle:
- zero both pointers and count;
- clear tx_err_o;
- go to IDLE, with no tx_complete_o.
REQ-033 SHALL give flush_i priority over wt_req_i, tx_start_i, pops and tx_abort_i in the same cycle; those inputs are ignored.
REQ-034 SHALL, on a write and a pop in the same cycle, leave count unchanged; a write when full SHALL still be dropped even if a pop occurs that cycle.
REQ-035 SHALL let tx_start_i with tx_len_i greater than count_o start anyway; the missing words stream as they are written.

Reset
REQ-036 SHALL, while rst_i is high, force:
- state to IDLE;
- pointers, count_o and remaining to 0;
- tx_pkt_len_o to 0;
- tx_err_o, tx_complete_o, tx_valid_o, tx_last_o, tx_busy_o and tx_pkt_req_o to 0.
REQ-037 SHALL define tx_data_o as don't-care after reset; storage is not reset.
REQ-038 SHALL abandon any packet in progress when rst_i is asserted mid-operation, with no tx_complete_o pulse.

Verification
REQ-039 SHALL cover: write 0x11,0x22,0x33; start len=3; tx_ready_i=1 -> data 11,22,33 on consecutive cycles, tx_last_o with 33, tx_complete_o one cycle after the 33 pop, count_o=0.
REQ-040 SHALL cover: write DEPTH+1 words -> count_o=DEPTH, tx_err_o=1, the last word dropped; flush -> count_o=0, tx_err_o=0.
REQ-041 SHALL cover: start len=0 with the FIFO empty -> tx_valid_o never high, tx_busy_o high 2 cycles, tx_complete_o pulses once.
REQ-042 SHALL cover: start len=4 with 2 words stored -> 2 pops, stall, 2 late writes stream, tx_last_o on word 4.
REQ-043 SHALL cover: simultaneous write and pop at count=DEPTH-1 -> count unchanged; pointer wrap past DEPTH -> data order preserved.
REQ-044 SHALL cover: tx_abort_i after 1 of 3 pops -> IDLE, tx_err_o=1, count_o=2, no tx_complete_o; rst_i mid-SEND -> all outputs 0 at once.

Source files
------------

// File: rtl/usbf_ep_tx_fifo_if.sv
// rtl/usbf_ep_tx_fifo_if.sv - write/packet-engine bundle for the endpoint TX FIFO
// Purpose: groups every non-clock, non-reset signal of usbf_ep_tx_fifo.
// Ports (signals):
//   wt_req_i/wt_data_i          - one-cycle write strobe and write data
//   flush_i                     - one-cycle flush strobe
//   tx_start_i/tx_len_i         - packet start strobe and length in words
//   tx_ready_i/tx_abort_i       - packet engine accept and abandon
//   tx_pkt_req_o/tx_pkt_len_o   - packet pending and latched length
//   tx_valid_o/tx_data_o/tx_last_o - streamed word, fall-through head of FIFO
//   tx_complete_o/tx_busy_o/tx_err_o/count_o - status
// Modports: master drives the inputs of the FIFO, slave is the FIFO itself.
interface usbf_ep_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int LEN_W  = 11
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wt_req_i;
    logic [DATA_W-1:0] wt_data_i;
    logic              flush_i;
    logic              tx_start_i;
    logic [LEN_W-1:0]  tx_len_i;
    logic              tx_ready_i;
    logic              tx_abort_i;
    logic              tx_pkt_req_o;
    logic [LEN_W-1:0]  tx_pkt_len_o;
    logic              tx_valid_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_last_o;
    logic              tx_complete_o;
    logic              tx_busy_o;
    logic              tx_err_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output wt_req_i, wt_data_i, flush_i, tx_start_i, tx_len_i, tx_ready_i, tx_abort_i,
        input  tx_pkt_req_o, tx_pkt_len_o, tx_valid_o, tx_data_o, tx_last_o,
               tx_complete_o, tx_busy_o, tx_err_o, count_o
    );

    modport slave (
        input  wt_req_i, wt_data_i, flush_i, tx_start_i, tx_len_i, tx_ready_i, tx_abort_i,
        output tx_pkt_req_o, tx_pkt_len_o, tx_valid_o, tx_data_o, tx_last_o,
               tx_complete_o, tx_busy_o, tx_err_o, count_o
    );
endinterface

// File: rtl/usbf_ep_tx_fifo.sv
// rtl/usbf_ep_tx_fifo.sv - USB endpoint transmit FIFO with packet sequencer
// Purpose: stores endpoint words and streams them as length-bounded packets
// to the packet engine, first-word fall-through, single PHY clock domain.
// Ports:
//   phy_clk_i - clock
//   rst_i     - asynchronous active-high reset
//   bus       - usbf_ep_tx_fifo_if.slave (write side, packet engine side, status)
module usbf_ep_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int LEN_W  = 11
) (
    input  logic               phy_clk_i,
    input  logic               rst_i,
    usbf_ep_tx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              full;
    logic              empty;
    logic              wr_en;
    logic              tx_valid;
    logic              pop;
    logic [AW:0]       count;

    // Extra pointer MSB distinguishes full from empty; the difference is the fill level.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Fullness is judged on the current pointers, so a same-cycle pop cannot rescue a write.
    assign wr_en    = bus.wt_req_i && !full && !bus.flush_i;
    assign tx_valid = (state_q == ST_SEND) && !empty && (remaining_q != '0);
    assign pop      = tx_valid && bus.tx_ready_i && !bus.flush_i;

    always_ff @(posedge phy_clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.wt_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        pkt_len_d   = pkt_len_q;
        err_d       = err_q;
        if (bus.flush_i) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            remaining_d = '0;
            err_d       = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (bus.wt_req_i && full) begin
                err_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                remaining_d = remaining_q - LEN_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.tx_start_i) begin
                        state_d     = ST_SEND;
                        remaining_d = bus.tx_len_i;
                        pkt_len_d   = bus.tx_len_i;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_abort_i) begin
                        state_d     = ST_IDLE;
                        remaining_d = '0;
                        err_d       = 1'b1;
                    end else if ((remaining_q == '0) || (pop && (remaining_q == LEN_ONE))) begin
                        // Zero-length packets spend exactly one cycle in SEND.
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge phy_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            pkt_len_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            pkt_len_q   <= pkt_len_d;
            err_q       <= err_d;
        end
    end

    assign bus.tx_pkt_req_o  = (state_q == ST_SEND);
    assign bus.tx_pkt_len_o  = pkt_len_q;
    assign bus.tx_valid_o    = tx_valid;
    assign bus.tx_data_o     = mem[rd_ptr_q[AW-1:0]];
    assign bus.tx_last_o     = tx_valid && (remaining_q == LEN_ONE);
    assign bus.tx_complete_o = (state_q == ST_DONE);
    assign bus.tx_busy_o     = (state_q != ST_IDLE);
    assign bus.tx_err_o      = err_q;
    assign bus.count_o       = count;
endmodule

// File: tb/tb_usbf_ep_tx_fifo.sv
// tb/tb_usbf_ep_tx_fifo.sv - directed self-checking bench for usbf_ep_tx_fifo
module tb_usbf_ep_tx_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 11;

    logic phy_clk;
    logic rst;
    int   checks;
    int   failures;

    usbf_ep_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

    usbf_ep_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .phy_clk_i (phy_clk),
        .rst_i     (rst),
        .bus       (bus)
    );

    initial phy_clk = 1'b0;
    always #5 phy_clk = ~phy_clk;

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wt_req_i  = 1'b1;
        bus.wt_data_i = d;
        tick();
        bus.wt_req_i  = 1'b0;
    endtask

    task automatic start(input logic [10:0] len);
        bus.tx_len_i   = len;
        bus.tx_start_i = 1'b1;
        tick();
        bus.tx_start_i = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
        checks++; if (bus.tx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.tx_valid_o); end
        checks++; if (bus.tx_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.tx_busy_o); end
        checks++; if (bus.tx_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.tx_err_o); end
        checks++; if (bus.tx_pkt_len_o !== 11'd0) begin failures++; $display("FAIL reset_pkt_len got=%0d exp=0", bus.tx_pkt_len_o); end
        checks++; if ({bus.tx_last_o, bus.tx_complete_o, bus.tx_pkt_req_o} !== 3'b000) begin failures++; $display("FAIL reset_misc got=%b exp=000", {bus.tx_last_o, bus.tx_complete_o, bus.tx_pkt_req_o}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        wr(8'h11); wr(8'h22); wr(8'h33);
        checks++; if (bus.count_o !== 4'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", bus.count_o); end
        checks++; if (bus.tx_data_o !== 8'h11) begin failures++; $display("FAIL basic_fwft got=%h exp=11", bus.tx_data_o); end
        start(11'd3);
        checks++; if ({bus.tx_busy_o, bus.tx_pkt_req_o} !== 2'b11) begin failures++; $display("FAIL basic_req got=%b exp=11", {bus.tx_busy_o, bus.tx_pkt_req_o}); end
        checks++; if (bus.tx_pkt_len_o !== 11'd3) begin failures++; $display("FAIL basic_pkt_len got=%0d exp=3", bus.tx_pkt_len_o); end
        bus.tx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.tx_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, bus.tx_valid_o); end
            checks++; if (bus.tx_data_o !== exp_d[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, bus.tx_data_o, exp_d[i]); end
            checks++; if (bus.tx_last_o !== (i == 2)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, bus.tx_last_o, (i == 2)); end
            tick();
        end
        checks++; if (bus.tx_complete_o !== 1'b1) begin failures++; $display("FAIL basic_complete got=%b exp=1", bus.tx_complete_o); end
        checks++; if (bus.count_o !== 4'd0) begin failures++; $display("FAIL basic_count_end got=%0d exp=0", bus.count_o); end
        checks++; if (bus.tx_valid_o !== 1'b0) begin failures++; $display("FAIL basic_valid_done got=%b exp=0", bus.tx_valid_o); end
        tick();
        checks++; if ({bus.tx_complete_o, bus.tx_busy_o} !== 2'b00) begin failures++; $display("FAIL basic_idle got=%b exp=00", {bus.tx_complete_o, bus.tx_busy_o}); end
        bus.tx_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) wr(8'hA0 + 8'(i));
        checks++; if (bus.tx_err_o !== 1'b0) begin failures++; $display("FAIL ovf_err_before got=%b exp=0", bus.tx_err_o); end
        wr(8'hFF);
        checks++; if (bus.count_o !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", bus.count_o); end
        checks++; if (bus.tx_err_o !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", bus.tx_err_o); end
        start(11'd8);
        bus.tx_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.tx_data_o !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, bus.tx_data_o, 8'hA0 + 8'(i)); end
            tick();
        end
        checks++; if ({bus.tx_complete_o, bus.count_o} !== {1'b1, 4'd0}) begin failures++; $display("FAIL ovf_drain got=%b/%0d exp=1/0", bus.tx_complete_o, bus.count_o); end
        bus.tx_ready_i = 1'b0;
        tick();
        wr(8'h01); wr(8'h02);
        do_flush();
        checks++; if (bus.count_o !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", bus.count_o); end
        checks++; if (bus.tx_err_o !== 1'b0) begin failures++; $display("FAIL flush_err got=%b exp=0", bus.tx_err_o); end
    endtask

    task automatic test_zero_len();
        int busy_cnt;
        int comp_cnt;
        int valid_cnt;
        busy_cnt = 0; comp_cnt = 0; valid_cnt = 0;
        bus.tx_ready_i = 1'b1;
        start(11'd0);
        for (int i = 0; i < 5; i++) begin
            if (bus.tx_busy_o === 1'b1) busy_cnt++;
            if (bus.tx_complete_o === 1'b1) comp_cnt++;
            if (bus.tx_valid_o !== 1'b0) valid_cnt++;
            tick();
        end
        bus.tx_ready_i = 1'b0;
        checks++; if (busy_cnt !== 2) begin failures++; $display("FAIL zlp_busy_cycles got=%0d exp=2", busy_cnt); end
        checks++; if (comp_cnt !== 1) begin failures++; $display("FAIL zlp_complete got=%0d exp=1", comp_cnt); end
        checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL zlp_valid got=%0d exp=0", valid_cnt); end
    endtask

    task automatic test_underrun();
        wr(8'h41); wr(8'h42);
        start(11'd4);
        bus.tx_ready_i = 1'b1;
        checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'h41}) begin failures++; $display("FAIL und_w1 got=%b/%h exp=1/41", bus.tx_valid_o, bus.tx_data_o); end
        tick();
        checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'h42}) begin failures++; $display("FAIL und_w2 got=%b/%h exp=1/42", bus.tx_valid_o, bus.tx_data_o); end
        tick();
        checks++; if ({bus.tx_valid_o, bus.tx_busy_o, bus.tx_pkt_req_o} !== 3'b011) begin failures++; $display("FAIL und_stall got=%b exp=011", {bus.tx_valid_o, bus.tx_busy_o, bus.tx_pkt_req_o}); end
        tick();
        checks++; if (bus.tx_valid_o !== 1'b0) begin failures++; $display("FAIL und_stall2 got=%b exp=0", bus.tx_valid_o); end
        bus.wt_req_i = 1'b1; bus.wt_data_i = 8'h43;
        tick();
        bus.wt_data_i = 8'h44;
        checks++; if ({bus.tx_valid_o, bus.tx_data_o, bus.tx_last_o} !== {1'b1, 8'h43, 1'b0}) begin failures++; $display("FAIL und_w3 got=%b/%h/%b exp=1/43/0", bus.tx_valid_o, bus.tx_data_o, bus.tx_last_o); end
        tick();
        bus.wt_req_i = 1'b0;
        checks++; if (bus.count_o !== 4'd1) begin failures++; $display("FAIL und_count got=%0d exp=1", bus.count_o); end
        checks++; if ({bus.tx_valid_o, bus.tx_data_o, bus.tx_last_o} !== {1'b1, 8'h44, 1'b1}) begin failures++; $display("FAIL und_w4 got=%b/%h/%b exp=1/44/1", bus.tx_valid_o, bus.tx_data_o, bus.tx_last_o); end
        tick();
        checks++; if ({bus.tx_complete_o, bus.count_o} !== {1'b1, 4'd0}) begin failures++; $display("FAIL und_complete got=%b/%0d exp=1/0", bus.tx_complete_o, bus.count_o); end
        tick();
        bus.tx_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DEPTH - 1; i++) wr(8'h50 + 8'(i));
        checks++; if (bus.count_o !== 4'd7) begin failures++; $display("FAIL wrap_fill got=%0d exp=7", bus.count_o); end
        start(11'd8);
        bus.tx_ready_i = 1'b1;
        bus.wt_req_i = 1'b1; bus.wt_data_i = 8'h57;
        checks++; if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, 8'h50}) begin failures++; $display("FAIL wrap_w0 got=%b/%h exp=1/50", bus.tx_valid_o, bus.tx_data_o); end
        tick();
        bus.wt_req_i = 1'b0;
        checks++; if (bus.count_o !== 4'd7) begin failures++; $display("FAIL wrap_wr_pop_count got=%0d exp=7", bus.count_o); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if ({bus.tx_valid_o, bus.tx_data_o, bus.tx_last_o} !== {1'b1, 8'h50 + 8'(i), (i == DEPTH - 1)}) begin failures++; $display("FAIL wrap_w%0d got=%b/%h/%b exp=1/%h/%b", i, bus.tx_valid_o, bus.tx_data_o, bus.tx_last_o, 8'h50 + 8'(i), (i == DEPTH - 1)); end
            tick();
        end
        checks++; if ({bus.tx_complete_o, bus.count_o} !== {1'b1, 4'd0}) begin failures++; $display("FAIL wrap_complete got=%b/%0d exp=1/0", bus.tx_complete_o, bus.count_o); end
        tick();
        bus.tx_ready_i = 1'b0;
    endtask

    task automatic test_abort_reset();
        wr(8'h61); wr(8'h62); wr(8'h63);
        start(11'd3);
        bus.tx_ready_i = 1'b1;
        checks++; if (bus.tx_data_o !== 8'h61) begin failures++; $display("FAIL abort_w0 got=%h exp=61", bus.tx_data_o); end
        tick();
        bus.tx_ready_i = 1'b0;
        bus.tx_abort_i = 1'b1;
        tick();
        bus.tx_abort_i = 1'b0;
        checks++; if ({bus.tx_busy_o, bus.tx_err_o, bus.tx_complete_o} !== 3'b010) begin failures++; $display("FAIL abort_state got=%b exp=010", {bus.tx_busy_o, bus.tx_err_o, bus.tx_complete_o}); end
        checks++; if ({bus.count_o, bus.tx_data_o} !== {4'd2, 8'h62}) begin failures++; $display("FAIL abort_kept got=%0d/%h exp=2/62", bus.count_o, bus.tx_data_o); end
        tick();
        checks++; if (bus.tx_complete_o !== 1'b0) begin failures++; $display("FAIL abort_no_complete got=%b exp=0", bus.tx_complete_o); end
        do_flush();
        wr(8'h71);
        start(11'd2);
        checks++; if ({bus.tx_busy_o, bus.tx_valid_o, bus.count_o} !== {2'b11, 4'd1}) begin failures++; $display("FAIL rst_pre got=%b/%b/%0d exp=1/1/1", bus.tx_busy_o, bus.tx_valid_o, bus.count_o); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.tx_busy_o, bus.tx_valid_o, bus.tx_pkt_req_o, bus.tx_last_o, bus.tx_complete_o, bus.tx_err_o} !== 6'b0) begin failures++; $display("FAIL rst_mid_flags got=%b exp=000000", {bus.tx_busy_o, bus.tx_valid_o, bus.tx_pkt_req_o, bus.tx_last_o, bus.tx_complete_o, bus.tx_err_o}); end
        checks++; if ({bus.count_o, bus.tx_pkt_len_o} !== {4'd0, 11'd0}) begin failures++; $display("FAIL rst_mid_count got=%0d/%0d exp=0/0", bus.count_o, bus.tx_pkt_len_o); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.tx_complete_o !== 1'b0) begin failures++; $display("FAIL rst_no_complete got=%b exp=0", bus.tx_complete_o); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.wt_req_i = 1'b0; bus.wt_data_i = '0; bus.flush_i = 1'b0;
        bus.tx_start_i = 1'b0; bus.tx_len_i = '0; bus.tx_ready_i = 1'b0; bus.tx_abort_i = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_zero_len();
        test_underrun();
        test_wrap();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
